pb_poll_master: RTL
===================

Name: pb_poll_master

Overview:
- Avalon-MM read initiator that periodically polls a read-only PIO slave (pushbutton input register, registered readdata, read latency 1).
- Debounces each returned bit, holds the debounced button state, and captures press (falling) edges into a sticky register that drives an interrupt.
- Sits between the system interconnect and a hardware consumer of button events, so button polling needs no CPU involvement.

Parameters:
- DATA_W, 4, number of polled bits (readdata[DATA_W-1:0]).
- POLL_DIV, 50000, clocks between poll ticks (1 ms at 50 MHz); must be at least 8.
- DEBOUNCE_N, 4, consecutive differing samples required to accept a new bit value; range 1..15.
- READ_LATENCY, 1, fixed cycles from accepted read to valid readdata; range 1..3.
- POLL_ADDR, 0, word address driven during polls.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- enable  in  1  polling enable
- avm_address  out  2  Avalon address, constant POLL_ADDR
- avm_read  out  1  Avalon read request
- avm_waitrequest  in  1  slave stall
- avm_readdata  in  32  slave read data
- state_o  out  DATA_W  debounced button levels (active-low buttons)
- edge_o  out  DATA_W  sticky press-edge capture
- edge_clr  in  DATA_W  per-bit clear of edge_o
- irq  out  1  OR-reduction of edge_o
- err_o  out  1  sticky bus-timeout flag

Behaviour:
- Reset and clock: reset reset_n, asynchronous, active-low; clock clk.
- Reset values: avm_read=0, state_o=all ones, edge_o=0, irq=0, err_o=0. The FSM enters IDLE. The poll timer loads POLL_DIV-1 and all debounce counters are 0.
- Poll timer:
  - Decrements every cycle while enable=1.
  - At 0 it raises a one-cycle poll tick and reloads POLL_DIV-1.
  - While enable=0 it is held at POLL_DIV-1.
  - A tick arriving when the FSM is not in IDLE is dropped; it is not queued.
- FSM states: IDLE, REQ, LAT, CAPT.
  - IDLE -> REQ on tick.
  - REQ: avm_read=1. Hold avm_read and avm_address stable while avm_waitrequest=1. When avm_waitrequest=0 the read is accepted; go to LAT with the latency counter at READ_LATENCY-1. avm_read deasserts the cycle after acceptance.
  - LAT: decrement to 0. At 0, avm_readdata is valid in the following cycle; go to CAPT.
  - CAPT: sample avm_readdata[DATA_W-1:0] and update the debouncers; go to IDLE.
- Exactly one read is outstanding at a time.
- Dropping enable mid-transaction completes the transaction, including CAPT, then the FSM stays in IDLE.
- Debounce, per bit, at each CAPT:
  - If sample == state_o[i], counter := 0.
  - Otherwise counter increments. When it reaches DEBOUNCE_N, state_o[i] := sample and counter := 0.
  - With DEBOUNCE_N=1, state_o follows every sample.
- Edge capture:
  - A debounced 1->0 transition on state_o[i] sets edge_o[i] in the same cycle state_o updates.
  - edge_clr[i] clears edge_o[i] the next cycle.
  - Simultaneous set and clear on the same bit: set wins.
- irq = |edge_o, registered, so irq follows edge_o by 0 cycles (derived from the register).
- Bits above DATA_W in avm_readdata are ignored.

Optional Feature:
- Macro PB_POLL_TIMEOUT_EN.
- Defined:
  - An 8-bit counter runs in REQ.
  - If avm_waitrequest stays 1 for 255 consecutive cycles, deassert avm_read, set err_o (sticky until reset), skip capture, and return to IDLE.
  - Debounce state is unchanged.
- Undefined: REQ waits indefinitely and err_o is tied to 0.

Decomposition:
- Shared package pb_poll_pkg holds:
  - FSM state enum poll_state_t (IDLE, REQ, LAT, CAPT).
  - Constant TIMEOUT_CYCLES=255.
  - Function clog2 for counter widths.
- One natural sub-module, pb_debounce_bit: per-bit counter, state register and falling-edge strobe, instantiated DATA_W times in a generate loop.

Test Plan:
- Basic polling: POLL_DIV=8, waitrequest=0, readdata=0xF constant -> avm_read pulses 1 cycle every 8 clocks, address=0, state_o stays 0xF, irq=0.
- Press and clear: DEBOUNCE_N=4, readdata becomes 0xE -> state_o=0xE on the 4th CAPT after the change, and edge_o=0x1 and irq=1 in that same cycle. Pulse edge_clr=0x1 -> edge_o=0, irq=0.
- Bounce rejection: readdata alternates 0xE/0xF each poll -> state_o remains 0xF, edge_o=0.
- Wait stall: waitrequest=1 for 5 cycles -> avm_read and address are held for 6 cycles, and exactly one CAPT follows. A tick during the stall is dropped, with no back-to-back read.
- Set/clear priority and reset: edge set and edge_clr on the same bit in the same cycle -> bit stays 1. Assert reset_n=0 mid-REQ -> avm_read=0 immediately and state_o=0xF.
- Timeout, with PB_POLL_TIMEOUT_EN: waitrequest stuck at 1 -> avm_read drops after 255 cycles, err_o=1, state_o unchanged, and the next tick issues a new read.

Source files
------------

// File: rtl/pb_poll_pkg.sv
// Shared types and helpers for the pushbutton poll master.
package pb_poll_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        LAT,
        CAPT
    } poll_state_t;

    localparam int unsigned TIMEOUT_CYCLES = 255;

    // Minimum width of 1 so that degenerate parameters still give a legal vector.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned w;
        w = 1;
        while ((32'd1 << w) < value) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/pb_poll_master_if.sv
// Avalon-MM read-only bus between the poll master and the PIO slave.
interface pb_poll_master_if;

    logic [1:0]  avm_address;
    logic        avm_read;
    logic        avm_waitrequest;
    logic [31:0] avm_readdata;

    modport master (
        output avm_address,
        output avm_read,
        input  avm_waitrequest,
        input  avm_readdata
    );

    modport slave (
        input  avm_address,
        input  avm_read,
        output avm_waitrequest,
        output avm_readdata
    );

endinterface

// File: rtl/pb_debounce_bit.sv
// One debounced button bit: agreement counter, level register and press strobe.
module pb_debounce_bit
    import pb_poll_pkg::*;
#(
    parameter int unsigned DEBOUNCE_N = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic capt,
    input  logic sample,
    output logic state,
    output logic fall
);

    localparam int unsigned    CW       = clog2(DEBOUNCE_N + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_N);

    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic          state_q, state_d;

    always_comb begin
        cnt_inc = cnt_q + CW'(1);
        cnt_d   = cnt_q;
        state_d = state_q;
        fall    = 1'b0;
        if (capt) begin
            if (sample == state_q) begin
                cnt_d = '0;
            end else if (cnt_inc == CNT_LAST) begin
                cnt_d   = '0;
                state_d = sample;
                fall    = state_q & ~sample;
            end else begin
                cnt_d = cnt_inc;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q   <= '0;
            state_q <= 1'b1;
        end else begin
            cnt_q   <= cnt_d;
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/pb_poll_master.sv
// Periodic Avalon-MM poller of a pushbutton PIO with debounce and sticky press capture.
// Optional bus timeout enabled by defining PB_POLL_TIMEOUT_EN.
module pb_poll_master
    import pb_poll_pkg::*;
#(
    parameter int unsigned DATA_W       = 4,
    parameter int unsigned POLL_DIV     = 50000,
    parameter int unsigned DEBOUNCE_N   = 4,
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned POLL_ADDR    = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    pb_poll_master_if.master  avm,
    output logic [DATA_W-1:0] state_o,
    output logic [DATA_W-1:0] edge_o,
    input  logic [DATA_W-1:0] edge_clr,
    output logic              irq,
    output logic              err_o
);

    localparam int unsigned   TW         = clog2(POLL_DIV);
    localparam logic [TW-1:0] TIMER_LOAD = TW'(POLL_DIV - 1);
    localparam int unsigned   LW         = clog2(READ_LATENCY);
    localparam logic [LW-1:0] LAT_LOAD   = LW'(READ_LATENCY - 1);

    poll_state_t       state_q, state_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [LW-1:0]     lat_q, lat_d;
    logic              tick, capt, timeout;
    logic [DATA_W-1:0] fall, edge_q, edge_d;
    logic              unused_rdata;

    // Ticks that land outside IDLE are simply lost; the timer never waits on the FSM.
    always_comb begin
        tick    = 1'b0;
        timer_d = timer_q - TW'(1);
        if (!enable) begin
            timer_d = TIMER_LOAD;
        end else if (timer_q == '0) begin
            tick    = 1'b1;
            timer_d = TIMER_LOAD;
        end
    end

    always_comb begin
        state_d = state_q;
        lat_d   = lat_q;
        capt    = 1'b0;
        unique case (state_q)
            IDLE: if (tick) state_d = REQ;
            REQ: begin
                if (!avm.avm_waitrequest) begin
                    state_d = LAT;
                    lat_d   = LAT_LOAD;
                end else if (timeout) begin
                    state_d = IDLE;
                end
            end
            LAT: begin
                if (lat_q == '0) state_d = CAPT;
                else             lat_d   = lat_q - LW'(1);
            end
            CAPT: begin
                capt    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            timer_q <= TIMER_LOAD;
            lat_q   <= '0;
            edge_q  <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            lat_q   <= lat_d;
            edge_q  <= edge_d;
        end
    end

`ifdef PB_POLL_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] to_q, to_d;
    logic       err_q;

    // Counts consecutive stalled REQ cycles; fires on the TIMEOUT_CYCLES-th one.
    always_comb begin
        timeout = (state_q == REQ) && avm.avm_waitrequest && (to_q == TO_LAST);
        to_d    = '0;
        if ((state_q == REQ) && avm.avm_waitrequest && !timeout) begin
            to_d = to_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            to_q  <= '0;
            err_q <= 1'b0;
        end else begin
            to_q  <= to_d;
            err_q <= err_q | timeout;
        end
    end

    assign err_o = err_q;
`else
    assign timeout = 1'b0;
    assign err_o   = 1'b0;
`endif

    for (genvar i = 0; i < DATA_W; i++) begin : g_bit
        pb_debounce_bit #(
            .DEBOUNCE_N (DEBOUNCE_N)
        ) u_bit (
            .clk     (clk),
            .reset_n (reset_n),
            .capt    (capt),
            .sample  (avm.avm_readdata[i]),
            .state   (state_o[i]),
            .fall    (fall[i])
        );
    end

    // A new press outranks a clear arriving in the same cycle.
    assign edge_d = (edge_q & ~edge_clr) | fall;

    assign edge_o          = edge_q;
    assign irq             = |edge_q;
    assign avm.avm_read    = (state_q == REQ);
    assign avm.avm_address = 2'(POLL_ADDR);
    assign unused_rdata    = ^avm.avm_readdata;

endmodule
